// File: rtl/lvds_frame_pkg.sv
// rtl/lvds_frame_pkg.sv - shared state type, default preamble words and counter widths
package lvds_frame_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   localparam logic [15:0] DEF_FILL_WORD = 16'hFFFF;
   localparam logic [15:0] DEF_SYNC_WORD = 16'hAAAA;
   localparam int          FRAME_CNT_W   = 16;
   localparam int          ERR_CNT_W     = 8;
   localparam int          WORD_CNT_W    = 16;

endpackage

// File: rtl/lvds_preamble_det.sv
// rtl/lvds_preamble_det.sv - lane-0 fill run counter with sync-word compare
// o_hit is a single-cycle strobe when SYNC_WORD follows at least FILL_CNT fill words.
module lvds_preamble_det
   import lvds_frame_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                FILL_CNT  = 2,
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEF_FILL_WORD),
   parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEF_SYNC_WORD)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_word,
   input  logic              i_en,
   input  logic              i_clr,
   output logic              o_hit
);
   localparam int           FW      = (FILL_CNT < 1) ? 1 : $clog2(FILL_CNT + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(FILL_CNT);

   logic [FW-1:0] r_fill;

   assign o_hit = i_en && !i_clr && (i_word == SYNC_WORD) && (r_fill == FILL_MAX);

   // Saturating run length; any non-fill word (sync included) restarts the hunt.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fill <= '0;
      end else if (!i_en || i_clr || (i_word != FILL_WORD)) begin
         r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
         r_fill <= r_fill + 1'b1;
      end
   end

endmodule

// File: rtl/lvds_frame_rx.sv
// rtl/lvds_frame_rx.sv - multi-lane LVDS frame receiver: preamble hunt, payload stream, counters
// Define LVDS_FRAME_CHECKSUM_EN to expect a per-lane wrapping-sum trailer after each payload.
module lvds_frame_rx
   import lvds_frame_pkg::*;
#(
   parameter int                DATA_W      = 16,
   parameter int                NUM_CH      = 1,
   parameter int                FILL_CNT    = 2,
   parameter logic [DATA_W-1:0] FILL_WORD   = DATA_W'(DEF_FILL_WORD),
   parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(DEF_SYNC_WORD),
   parameter int                PAYLOAD_LEN = 64
) (
   input  logic                     lvds_clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_CH*DATA_W-1:0] lvds_ch,
   output logic                     out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     out_sof,
   output logic                     out_eof,
   output logic                     out_abort,
`ifdef LVDS_FRAME_CHECKSUM_EN
   output logic                     out_crc_ok,
`endif
   output logic [FRAME_CNT_W-1:0]   frame_cnt,
   output logic [ERR_CNT_W-1:0]     err_cnt
);
   localparam logic [WORD_CNT_W-1:0] LAST_IDX = WORD_CNT_W'(PAYLOAD_LEN - 1);

   state_t                   r_state, w_state_nx;
   logic [NUM_CH*DATA_W-1:0] r_s1;
   logic [WORD_CNT_W-1:0]    r_cnt, w_cnt_nx;
   logic                     w_hit, w_det_clr;
   logic                     w_valid_nx, w_sof_nx, w_eof_nx, w_abort_nx;
   logic                     w_frame_inc, w_err_inc;

   assign w_det_clr = (r_state != HUNT);

   lvds_preamble_det #(
      .DATA_W    (DATA_W),
      .FILL_CNT  (FILL_CNT),
      .FILL_WORD (FILL_WORD),
      .SYNC_WORD (SYNC_WORD)
   ) u_det (
      .i_clk  (lvds_clk),
      .i_rst  (rst),
      .i_word (r_s1[DATA_W-1:0]),
      .i_en   (en),
      .i_clr  (w_det_clr),
      .o_hit  (w_hit)
   );

`ifdef LVDS_FRAME_CHECKSUM_EN
   logic [NUM_CH-1:0][DATA_W-1:0] r_sum;
   logic                          w_sum_ok, w_crc_ok_nx;

   always_ff @(posedge lvds_clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
      end else if (w_hit) begin
         r_sum <= '0;
      end else if (r_state == PAYLOAD) begin
         for (int k = 0; k < NUM_CH; k++)
            r_sum[k] <= r_sum[k] + r_s1[k*DATA_W +: DATA_W];
      end
   end

   // In CHECK, S1 holds the trailer word of every lane.
   always_comb begin
      w_sum_ok = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
         if (r_s1[k*DATA_W +: DATA_W] != r_sum[k]) w_sum_ok = 1'b0;
   end
`endif

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_valid_nx  = 1'b0;
      w_sof_nx    = 1'b0;
      w_eof_nx    = 1'b0;
      w_abort_nx  = 1'b0;
      w_frame_inc = 1'b0;
      w_err_inc   = 1'b0;
`ifdef LVDS_FRAME_CHECKSUM_EN
      w_crc_ok_nx = 1'b0;
`endif
      case (r_state)
         HUNT: begin
            if (w_hit) begin
               w_state_nx = PAYLOAD;
               w_cnt_nx   = '0;
            end
         end
         PAYLOAD: begin
            if (!en) begin
               w_state_nx = HUNT;
               w_abort_nx = 1'b1;
               w_err_inc  = 1'b1;
            end else begin
               w_valid_nx = 1'b1;
               w_sof_nx   = (r_cnt == '0);
               w_cnt_nx   = r_cnt + 1'b1;
               if (r_cnt == LAST_IDX) begin
                  w_eof_nx    = 1'b1;
`ifdef LVDS_FRAME_CHECKSUM_EN
                  w_state_nx  = CHECK;
`else
                  w_state_nx  = HUNT;
                  w_frame_inc = 1'b1;
`endif
               end
            end
         end
`ifdef LVDS_FRAME_CHECKSUM_EN
         CHECK: begin
            w_state_nx = HUNT;
            if (en && w_sum_ok) begin
               w_crc_ok_nx = 1'b1;
               w_frame_inc = 1'b1;
            end else begin
               w_abort_nx = 1'b1;
               w_err_inc  = 1'b1;
            end
         end
`endif
         default: w_state_nx = HUNT;
      endcase
   end

   always_ff @(posedge lvds_clk or posedge rst) begin
      if (rst) begin
         r_s1       <= '0;
         r_state    <= HUNT;
         r_cnt      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         out_abort  <= 1'b0;
         frame_cnt  <= '0;
         err_cnt    <= '0;
`ifdef LVDS_FRAME_CHECKSUM_EN
         out_crc_ok <= 1'b0;
`endif
      end else begin
         r_s1      <= lvds_ch;
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         out_valid <= w_valid_nx;
         out_sof   <= w_sof_nx;
         out_eof   <= w_eof_nx;
         out_abort <= w_abort_nx;
`ifdef LVDS_FRAME_CHECKSUM_EN
         out_crc_ok <= w_crc_ok_nx;
`endif
         if (w_valid_nx) out_data <= r_s1;
         if (w_frame_inc) frame_cnt <= frame_cnt + 1'b1;
         if (w_err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_lvds_frame_rx.sv
// tb/tb_lvds_frame_rx.sv - randomized self-checking bench for lvds_frame_rx
`timescale 1ns/1ps
module tb_lvds_frame_rx;
   localparam logic [15:0] FILL = 16'hFFFF;
   localparam logic [15:0] SYNC = 16'hAAAA;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, en_b;
   logic [15:0] ch_a;
   logic [63:0] ch_b;
   logic        va, sa, ea, aa, vb, sb, eb, ab;
   logic [15:0] da, fa, fb;
   logic [63:0] db;
   logic [7:0]  xa, xb;
`ifdef LVDS_FRAME_CHECKSUM_EN
   logic        ca, cb;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int abort_a = 0, abort_b = 0, crc_a = 0, crc_b = 0;
   int first_valid_cyc = -1;
   logic [65:0] obs_a[$], exp_a[$], obs_b[$];
   logic [15:0] pay[$];

   lvds_frame_rx #(.DATA_W(16), .NUM_CH(1), .FILL_CNT(2), .FILL_WORD(16'hFFFF),
                   .SYNC_WORD(16'hAAAA), .PAYLOAD_LEN(64)) u_dut_a (
      .lvds_clk(clk), .rst(rst), .en(en_a), .lvds_ch(ch_a),
      .out_valid(va), .out_data(da), .out_sof(sa), .out_eof(ea), .out_abort(aa),
`ifdef LVDS_FRAME_CHECKSUM_EN
      .out_crc_ok(ca),
`endif
      .frame_cnt(fa), .err_cnt(xa));

   lvds_frame_rx #(.DATA_W(16), .NUM_CH(4), .FILL_CNT(2), .FILL_WORD(16'hFFFF),
                   .SYNC_WORD(16'hAAAA), .PAYLOAD_LEN(1)) u_dut_b (
      .lvds_clk(clk), .rst(rst), .en(en_b), .lvds_ch(ch_b),
      .out_valid(vb), .out_data(db), .out_sof(sb), .out_eof(eb), .out_abort(ab),
`ifdef LVDS_FRAME_CHECKSUM_EN
      .out_crc_ok(cb),
`endif
      .frame_cnt(fb), .err_cnt(xb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Output monitor: beats are {sof, eof, data}
   always @(negedge clk) begin
      if (!rst) begin
         if (va) begin
            obs_a.push_back({sa, ea, 48'd0, da});
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (aa) abort_a++;
         if (vb) obs_b.push_back({sb, eb, db});
         if (ab) abort_b++;
`ifdef LVDS_FRAME_CHECKSUM_EN
         if (ca) crc_a++;
         if (cb) crc_b++;
`endif
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] noise();
      logic [15:0] w;
      do w = 16'($urandom); while (w == FILL || w == SYNC);
      return w;
   endfunction

   task automatic drive_a(input logic [15:0] w, input logic e);
      ch_a = w; en_a = e;
      @(posedge clk); #1;
   endtask

   task automatic drive_b(input logic [63:0] w, input logic e);
      ch_b = w; en_b = e;
      @(posedge clk); #1;
   endtask

   task automatic preamble_a(input int nfill);
      for (int i = 0; i < nfill; i++) drive_a(FILL, 1'b1);
      drive_a(SYNC, 1'b1);
   endtask

   // Sends pay[] as a frame body and records the beats the spec says must come out.
   task automatic payload_a();
      logic [15:0] sum = '0;
      for (int i = 0; i < pay.size(); i++) begin
         drive_a(pay[i], 1'b1);
         exp_a.push_back({(i == 0), (i == pay.size() - 1), 48'd0, pay[i]});
         sum += pay[i];
      end
`ifdef LVDS_FRAME_CHECKSUM_EN
      drive_a(sum, 1'b1);
`endif
   endtask

   task automatic settle();
      for (int i = 0; i < 5; i++) drive_a(noise(), 1'b1);
   endtask

   task automatic clear_obs();
      obs_a.delete(); exp_a.delete(); obs_b.delete();
      abort_a = 0; abort_b = 0; crc_a = 0; crc_b = 0;
      first_valid_cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ch_a = FILL; ch_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({va, sa, ea, aa} !== 4'b0) begin errors++; $display("FAIL reset_flags_a: got %b required 0000", {va, sa, ea, aa}); end
      checks++; if (da !== 16'h0) begin errors++; $display("FAIL reset_data_a: got %h required 0000", da); end
      checks++; if (fa !== 16'h0 || xa !== 8'h0) begin errors++; $display("FAIL reset_cnt_a: got %h/%h required 0/0", fa, xa); end
      checks++; if ({vb, sb, eb, ab} !== 4'b0 || db !== 64'h0) begin errors++; $display("FAIL reset_b: got %b %h required 0", {vb, sb, eb, ab}, db); end
      checks++; if (fb !== 16'h0 || xb !== 8'h0) begin errors++; $display("FAIL reset_cnt_b: got %h/%h required 0/0", fb, xb); end
`ifdef LVDS_FRAME_CHECKSUM_EN
      checks++; if (ca !== 1'b0 || cb !== 1'b0) begin errors++; $display("FAIL reset_crc_ok: got %b%b required 00", ca, cb); end
`endif
      rst = 1'b0; en_a = 1'b1; en_b = 1'b1; ch_a = 16'h0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int start_cyc, bad;
      clear_obs();
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(16'(i));
      preamble_a(2);
      start_cyc = cyc;
      payload_a();
      settle();
      checks++; if (obs_a.size() != 64) begin errors++; $display("FAIL basic_beats: got %0d required 64", obs_a.size()); end
      bad = -1;
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) if (obs_a[i] !== exp_a[i]) begin bad = i; break; end
      checks++; if (bad >= 0) begin errors++; $display("FAIL basic_data: beat %0d got %h required %h", bad, obs_a[bad], exp_a[bad]); end
      checks++; if (first_valid_cyc - start_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", first_valid_cyc - start_cyc); end
      checks++; if (fa !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d required 1", fa); end
   endtask

   task automatic test_short_preamble();
      int bad;
      clear_obs();
      drive_a(FILL, 1'b1);
      drive_a(SYNC, 1'b1);
      for (int i = 0; i < 64; i++) drive_a(noise(), 1'b1);
      settle();
      checks++; if (obs_a.size() != 0) begin errors++; $display("FAIL short_preamble: got %0d beats required 0", obs_a.size()); end
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(16'($urandom));
      preamble_a(5);
      payload_a();
      settle();
      checks++; if (obs_a.size() != 64) begin errors++; $display("FAIL long_fill_beats: got %0d required 64", obs_a.size()); end
      bad = -1;
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) if (obs_a[i] !== exp_a[i]) begin bad = i; break; end
      checks++; if (bad >= 0) begin errors++; $display("FAIL long_fill_data: beat %0d got %h required %h", bad, obs_a[bad], exp_a[bad]); end
      checks++; if (fa !== 16'd2) begin errors++; $display("FAIL long_fill_frame_cnt: got %0d required 2", fa); end
   endtask

   task automatic test_back_to_back();
      int bad, p;
      logic [15:0] f0;
      clear_obs();
      f0 = fa;
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(16'($urandom));
      p = $urandom_range(0, 61);
      pay[p] = FILL; pay[p+1] = FILL; pay[p+2] = SYNC;
      preamble_a(2);
      payload_a();
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(16'($urandom));
      preamble_a(2);
      payload_a();
      settle();
      checks++; if (obs_a.size() != 128) begin errors++; $display("FAIL b2b_beats: got %0d required 128", obs_a.size()); end
      bad = -1;
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) if (obs_a[i] !== exp_a[i]) begin bad = i; break; end
      checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_data: beat %0d got %h required %h", bad, obs_a[bad], exp_a[bad]); end
      checks++; if (fa !== 16'(f0 + 2)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required %0d", fa, 16'(f0 + 2)); end
   endtask

   task automatic test_multilane();
      logic [63:0] word;
      clear_obs();
      drive_b({noise(), noise(), noise(), FILL}, 1'b1);
      drive_b({noise(), noise(), noise(), FILL}, 1'b1);
      drive_b({noise(), noise(), noise(), SYNC}, 1'b1);
      word = {16'h3333, 16'h2222, 16'h1111, 16'($urandom)};
      drive_b(word, 1'b1);
`ifdef LVDS_FRAME_CHECKSUM_EN
      drive_b(word, 1'b1);
`endif
      for (int i = 0; i < 5; i++) drive_b({noise(), noise(), noise(), noise()}, 1'b1);
      checks++; if (obs_b.size() != 1) begin errors++; $display("FAIL multilane_beats: got %0d required 1", obs_b.size()); end
      else begin
         checks++; if (obs_b[0] !== {2'b11, word}) begin errors++; $display("FAIL multilane_data: got %h required %h", obs_b[0], {2'b11, word}); end
      end
      checks++; if (fb !== 16'd1) begin errors++; $display("FAIL multilane_frame_cnt: got %0d required 1", fb); end
`ifdef LVDS_FRAME_CHECKSUM_EN
      checks++; if (crc_b != 1) begin errors++; $display("FAIL multilane_crc_ok: got %0d pulses required 1", crc_b); end
`endif
   endtask

`ifdef LVDS_FRAME_CHECKSUM_EN
   task automatic test_checksum();
      logic [15:0] f0;
      logic [7:0]  e0;
      clear_obs();
      f0 = fa; e0 = xa;
      preamble_a(2);
      for (int i = 1; i <= 64; i++) drive_a(16'(i), 1'b1);
      drive_a(16'h0820, 1'b1);
      settle();
      checks++; if (crc_a != 1 || abort_a != 0) begin errors++; $display("FAIL crc_good: got crc %0d abort %0d required 1/0", crc_a, abort_a); end
      checks++; if (fa !== 16'(f0 + 1)) begin errors++; $display("FAIL crc_good_frame_cnt: got %0d required %0d", fa, 16'(f0 + 1)); end
      preamble_a(2);
      for (int i = 1; i <= 64; i++) drive_a(16'(i), 1'b1);
      drive_a(16'h0821, 1'b1);
      settle();
      checks++; if (crc_a != 1 || abort_a != 1) begin errors++; $display("FAIL crc_bad: got crc %0d abort %0d required 1/1", crc_a, abort_a); end
      checks++; if (xa !== 8'(e0 + 1) || fa !== 16'(f0 + 1)) begin errors++; $display("FAIL crc_bad_cnts: got err %0d frames %0d required %0d/%0d", xa, fa, 8'(e0 + 1), 16'(f0 + 1)); end
      checks++; if (obs_a.size() != 128 || obs_a[63][64] !== 1'b1) begin errors++; $display("FAIL crc_eof: got %0d beats, eof on beat 63 missing", obs_a.size()); end
   endtask
`endif

   // en low while S1 holds payload word k: words 0..k-1 emitted, then an abort.
   task automatic test_abort();
      int k, bad;
      logic [15:0] f0;
      logic [7:0]  e0;
      clear_obs();
      f0 = fa; e0 = xa;
      k = $urandom_range(1, 60);
      pay.delete();
      for (int i = 0; i < 64; i++) pay.push_back(16'($urandom));
      preamble_a(2);
      for (int i = 0; i <= k; i++) begin
         drive_a(pay[i], 1'b1);
         if (i < k) exp_a.push_back({(i == 0), 1'b0, 48'd0, pay[i]});
      end
      drive_a(pay[k+1], 1'b0);
      drive_a(noise(), 1'b0);
      settle();
      bad = -1;
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) if (obs_a[i] !== exp_a[i]) begin bad = i; break; end
      checks++; if (obs_a.size() != k || bad >= 0) begin errors++; $display("FAIL abort_beats: got %0d beats (first diff %0d) required %0d", obs_a.size(), bad, k); end
      checks++; if (abort_a != 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses required 1", abort_a); end
      checks++; if (xa !== 8'(e0 + 1)) begin errors++; $display("FAIL abort_err_cnt: got %0d required %0d", xa, 8'(e0 + 1)); end
      checks++; if (fa !== f0) begin errors++; $display("FAIL abort_frame_cnt: got %0d required %0d", fa, f0); end
   endtask

   task automatic test_reset_midframe();
      clear_obs();
      preamble_a(2);
      for (int i = 0; i < 5; i++) drive_a(16'($urandom), 1'b1);
      checks++; if (va !== 1'b1) begin errors++; $display("FAIL midframe_active: got valid %b required 1", va); end
      rst = 1'b1;
      #1;
      checks++; if ({va, sa, ea, aa} !== 4'b0 || da !== 16'h0) begin errors++; $display("FAIL midframe_reset_out: got %b %h required 0", {va, sa, ea, aa}, da); end
      checks++; if (fa !== 16'h0 || xa !== 8'h0) begin errors++; $display("FAIL midframe_reset_cnt: got %0d/%0d required 0/0", fa, xa); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      clear_obs();
      for (int i = 0; i < 70; i++) drive_a(16'($urandom), 1'b1);
      checks++; if (abort_a != 0 || obs_a.size() != 0) begin errors++; $display("FAIL midframe_after: got %0d aborts %0d beats required 0/0", abort_a, obs_a.size()); end
   endtask

   task automatic test_err_saturation();
      clear_obs();
      for (int n = 0; n < 300; n++) begin
         preamble_a(2);
         drive_a(noise(), 1'b1);
         drive_a(noise(), 1'b0);
      end
      settle();
      checks++; if (abort_a != 300) begin errors++; $display("FAIL sat_aborts: got %0d required 300", abort_a); end
      checks++; if (xa !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d required 255", xa); end
      checks++; if (fa !== 16'd0 || obs_a.size() != 0) begin errors++; $display("FAIL sat_no_frames: got %0d frames %0d beats required 0/0", fa, obs_a.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_preamble();
      test_back_to_back();
      test_multilane();
`ifdef LVDS_FRAME_CHECKSUM_EN
      test_checksum();
`endif
      test_abort();
      test_reset_midframe();
      test_err_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
